// File: rtl/io_pkg.sv
// Shared types and constants for the IN-instruction responder.
package io_pkg;
  typedef enum logic [1:0] {OCIOSO, AGUARDA, CAPTURA, SOLTA} estado_t;

  localparam int         DEBOUNCE_CYCLES_DEF = 250000;
  localparam int         DATA_W_DEF          = 32;
  localparam int         SW_W_DEF            = 4;
  localparam logic [3:0] ENTER_CODE          = 4'hF;
  localparam int         MAX_DIGITOS         = 3;
  localparam int         ACC_W               = 10;

  function automatic logic [ACC_W-1:0] acc_digito(input logic [ACC_W-1:0] acc, input logic [3:0] d);
    return ACC_W'(acc * 10) + ACC_W'(d);
  endfunction
endpackage

// File: rtl/debounce_botao.sv
// Button synchroniser and debouncer; raw is active-low, nivel is the accepted pin level (1 = released).
module debounce_botao
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic nivel,
  output logic borda_press,
  output logic borda_solta
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // cnt measures how long the synchronised pin has disagreed with the accepted level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      nivel       <= 1'b1;
      cnt         <= '0;
      borda_press <= 1'b0;
      borda_solta <= 1'b0;
    end else begin
      s1          <= raw;
      s2          <= s1;
      borda_press <= 1'b0;
      borda_solta <= 1'b0;
      if (s2 == nivel) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt         <= '0;
        nivel       <= s2;
        borda_press <= ~s2;
        borda_solta <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/io_in_responder.sv
// CPU IN-instruction responder: stalls the CPU until a debounced button press, then returns the switches.
// Optional IO_ACUMULA_DIGITOS_EN: multi-digit decimal entry (up to 3 digits, 4'hF enters early).
module io_in_responder
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int SW_W            = SW_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_in,
  input  logic              botao,
  input  logic [SW_W-1:0]   chaves,
  output logic              stall,
  output logic [DATA_W-1:0] dado_lido,
  output logic              dado_valido,
  output logic              ledin
);
  logic [SW_W-1:0] ch_s1, ch_s;
  logic            nivel, borda_press, borda_solta;
  estado_t         estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch_s1 <= '0;
      ch_s  <= '0;
    end else begin
      ch_s1 <= chaves;
      ch_s  <= ch_s1;
    end
  end

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock       (clock),
    .reset       (reset),
    .raw         (botao),
    .nivel       (nivel),
    .borda_press (borda_press),
    .borda_solta (borda_solta)
  );

`ifdef IO_ACUMULA_DIGITOS_EN
  logic [ACC_W-1:0] acc;
  logic [1:0]       ndig;
  logic [ACC_W-1:0] acc_novo;
  assign acc_novo = acc_digito(acc, ch_s[3:0]);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      dado_lido   <= '0;
      dado_valido <= 1'b0;
`ifdef IO_ACUMULA_DIGITOS_EN
      acc         <= '0;
      ndig        <= '0;
`endif
    end else begin
      dado_valido <= 1'b0;
      case (estado)
        OCIOSO: if (req_in) estado <= AGUARDA;
        AGUARDA: begin
          if (!req_in) begin
            estado <= OCIOSO;
`ifdef IO_ACUMULA_DIGITOS_EN
            acc    <= '0;
            ndig   <= '0;
`endif
          end else if (borda_press) begin
`ifdef IO_ACUMULA_DIGITOS_EN
            if (ch_s == SW_W'(ENTER_CODE)) begin
              estado      <= CAPTURA;
              dado_lido   <= DATA_W'(acc);
              dado_valido <= 1'b1;
              acc         <= '0;
              ndig        <= '0;
            end else if (ch_s <= SW_W'(9)) begin
              if (ndig == 2'(MAX_DIGITOS - 1)) begin
                estado      <= CAPTURA;
                dado_lido   <= DATA_W'(acc_novo);
                dado_valido <= 1'b1;
                acc         <= '0;
                ndig        <= '0;
              end else begin
                acc  <= acc_novo;
                ndig <= ndig + 1'b1;
              end
            end
`else
            estado      <= CAPTURA;
            dado_lido   <= DATA_W'(ch_s);
            dado_valido <= 1'b1;
`endif
          end
        end
        CAPTURA: estado <= SOLTA;
        // the level catches a release whose edge fired while still in CAPTURA
        SOLTA:   if (borda_solta || nivel) estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  // a request arriving in OCIOSO or SOLTA stalls immediately; reset drops it asynchronously
  assign stall = reset && ((estado == AGUARDA) ||
                           (req_in && (estado == OCIOSO || estado == SOLTA)));
  assign ledin = stall;
endmodule

// File: tb/tb_io_in_responder.sv
// Scoreboard bench for io_in_responder with DEBOUNCE_CYCLES=4.
module tb_io_in_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_in = 1'b0;
  logic        botao = 1'b1;
  logic [3:0]  chaves = 4'h0;
  logic        stall, dado_valido, ledin;
  logic [31:0] dado_lido;

  io_in_responder #(.DEBOUNCE_CYCLES(4), .DATA_W(32), .SW_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_in      (req_in),
    .botao       (botao),
    .chaves      (chaves),
    .stall       (stall),
    .dado_lido   (dado_lido),
    .dado_valido (dado_valido),
    .ledin       (ledin)
  );

  always #5 clock = ~clock;

  int          checks = 0, errors = 0;
  int          cyc = 0, pulses = 0, pulse_cyc = 0;
  logic [31:0] exp_q[$];

  always @(posedge clock) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: every pulse must match the oldest expected capture and coincide with stall=0
  always @(negedge clock) begin
    if (reset && dado_valido) begin
      logic [31:0] e;
      pulses++;
      pulse_cyc = cyc;
      check("pulse_stall", {31'b0, stall}, 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got dado_lido=%0d expected no pulse", dado_lido);
      end else begin
        e = exp_q.pop_front();
        if (dado_lido !== e) begin
          errors++;
          $display("FAIL dado_lido: got %0d expected %0d", dado_lido, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_pulse(input string nm, input int p0, input int t0);
    int n = 0;
    while (pulses == p0 && n < 40) begin @(negedge clock); #1; n++; end
    checks++;
    if (pulses == p0) begin
      errors++;
      $display("FAIL %s: got no dado_valido within 40 cycles expected one", nm);
    end else check({nm, "_latency"}, pulse_cyc - t0, 32'd7);
  endtask

  task automatic press_capture(input string nm, input logic [3:0] sw, input logic [31:0] exp);
    int p0, t0;
    chaves = sw;
    tick(3);
    exp_q.push_back(exp);
    p0 = pulses;
    botao = 1'b0;
    t0 = cyc;
    wait_pulse(nm, p0, t0);
  endtask

  task automatic reset_and_check();
    req_in = 1'b0;
    reset  = 1'b0;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_ledin", {31'b0, ledin}, 32'd0);
    check("rst_valid", {31'b0, dado_valido}, 32'd0);
    check("rst_dado", dado_lido, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

`ifdef IO_ACUMULA_DIGITOS_EN
  task automatic acc_press(input logic [3:0] sw);
    chaves = sw;
    tick(3);
    botao = 1'b0;
    tick(9);
    check("acc_stall", {31'b0, stall}, 32'd1);
    botao = 1'b1;
    tick(9);
  endtask
`endif

  initial begin
    int p0;
    reset_and_check();

    // abort before any press; a later press with no request is ignored
    req_in = 1'b1;
    chaves = 4'h3;
    #1;
    check("abort_stall_on", {31'b0, stall}, 32'd1);
    tick(4);
    req_in = 1'b0;
    tick(1);
    check("abort_stall_off", {31'b0, stall}, 32'd0);
    botao = 1'b0;
    tick(10);
    botao = 1'b1;
    tick(10);
    check("abort_pulses", pulses, 32'd0);
    check("abort_dado", dado_lido, 32'd0);

`ifdef IO_ACUMULA_DIGITOS_EN
    req_in = 1'b1;
    tick(2);
    acc_press(4'd1);
    acc_press(4'd2);
    acc_press(4'd12);
    check("acc_no_early_pulse", pulses, 32'd0);
    press_capture("acc_123", 4'd3, 32'd123);
    req_in = 1'b0;
    botao  = 1'b1;
    tick(9);
    req_in = 1'b1;
    tick(2);
    acc_press(4'd7);
    press_capture("acc_7", 4'hF, 32'd7);
    req_in = 1'b0;
    botao  = 1'b1;
    tick(9);
    check("acc_idle_stall", {31'b0, stall}, 32'd0);
`else
    // basic read
    req_in = 1'b1;
    #1;
    check("t1_stall_comb", {31'b0, stall}, 32'd1);
    check("t1_ledin_comb", {31'b0, ledin}, 32'd1);
    tick(3);
    check("t1_stall_wait", {31'b0, stall}, 32'd1);
    press_capture("t1", 4'h9, 32'd9);
    req_in = 1'b0;
    tick(1);
    check("t1_stall_after", {31'b0, stall}, 32'd0);
    botao = 1'b1;
    tick(8);

    // bounce: ten toggles two cycles apart, then a stable low
    req_in = 1'b1;
    chaves = 4'h5;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      botao = ~botao;
      tick(2);
    end
    check("t2_no_bounce_pulse", pulses, 32'd1);
    check("t2_stall", {31'b0, stall}, 32'd1);
    exp_q.push_back(32'd5);
    botao = 1'b0;
    wait_pulse("t2", 1, cyc);

    // button kept held: a new request must wait for release and a fresh press
    req_in = 1'b0;
    tick(2);
    req_in = 1'b1;
    tick(1);
    check("t3_stall_held", {31'b0, stall}, 32'd1);
    tick(10);
    check("t3_stall_still", {31'b0, stall}, 32'd1);
    check("t3_no_double", pulses, 32'd2);
    botao = 1'b1;
    tick(8);
    check("t3_stall_after_rel", {31'b0, stall}, 32'd1);
    press_capture("t3", 4'hA, 32'd10);
    req_in = 1'b0;
    botao  = 1'b1;
    tick(8);
`endif

    // reset while stalled
    req_in = 1'b1;
    tick(3);
    check("t5_stall_pre", {31'b0, stall}, 32'd1);
    p0 = pulses;
    reset_and_check();
    check("t5_no_pulse", pulses, p0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
